swm_tx_packer: RTL

- Parametrised Avalon-ST to SerialLite III TX gearbox.
- Packs consecutive IN_WIDTH-bit sink words into one OUT_WIDTH-bit burst beat; a packet maps to one burst.
- Sits between the streaming message source and the SerialLite III TX user interface.
- Adds the lane packing, partial-beat flush, registered output with backpressure hold, and protocol checking that a direct 1:1 pass-through lacks.

---
 rtl/swm_tx_packer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/swm_tx_packer.sv
// swm_tx_packer: Avalon-ST to SerialLite III TX gearbox, N sink words per beat.
// Optional error_tx event counter enabled by `define SWM_TX_ERR_CNT_EN.
module swm_tx_packer #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 256,
  parameter int SYNC_VALUE = 4
) (
  input  logic                 clk_in_clk,
  input  logic                 reset_in_rst,
  input  logic [IN_WIDTH-1:0]  avalonst_sink_data,
  input  logic                 avalonst_sink_valid,
  input  logic                 avalonst_sink_startofpacket,
  input  logic                 avalonst_sink_endofpacket,
  output logic                 avalonst_sink_ready,
  output logic [OUT_WIDTH-1:0] data_tx,
  output logic                 valid_tx,
  output logic                 start_of_burst_tx,
  output logic                 end_of_burst_tx,
  input  logic [3:0]           error_tx,
  output logic [7:0]           sync_tx,
  input  logic                 ready_tx,
  output logic                 protocol_err,
  output logic [15:0]          err_count
);

  localparam int N  = OUT_WIDTH / IN_WIDTH;
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  generate
    if ((OUT_WIDTH % IN_WIDTH) != 0 || N < 2) begin : g_bad_width
      $error("swm_tx_packer: OUT_WIDTH must be a multiple >= 2 of IN_WIDTH");
    end
  endgenerate

  logic [0:0]           state;
  logic [LW-1:0]        lane;
  logic [OUT_WIDTH-1:0] acc;
  logic                 first_beat;

  logic                 accept;
  logic                 take;
  logic                 last_lane;
  logic                 done;
  logic                 sob_n;
  logic [OUT_WIDTH-1:0] beat;

  assign avalonst_sink_ready = !valid_tx || ready_tx;
  assign sync_tx = 8'(SYNC_VALUE);

  assign accept    = avalonst_sink_valid && avalonst_sink_ready;
  assign take      = accept &&
                     (state == IN_PKT || avalonst_sink_startofpacket);
  assign last_lane = (lane == LW'(N - 1));
  assign done      = take && (last_lane || avalonst_sink_endofpacket);
  assign sob_n     = (state == IDLE) || first_beat;

  always_comb begin
    beat = acc;
    beat[IN_WIDTH*lane +: IN_WIDTH] = avalonst_sink_data;
  end

  always_ff @(posedge clk_in_clk) begin
    if (reset_in_rst) begin
      state        <= IDLE;
      lane         <= '0;
      acc          <= '0;
      first_beat   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      unique case (1'b1)
        accept && state == IDLE && !avalonst_sink_startofpacket:
          protocol_err <= 1'b1;
        accept && state == IN_PKT && avalonst_sink_startofpacket:
          protocol_err <= 1'b1;
        default: ;
      endcase
      if (take) begin
        if (done) begin
          acc        <= '0;
          lane       <= '0;
          first_beat <= 1'b0;
          state      <= avalonst_sink_endofpacket ? IDLE : IN_PKT;
        end else begin
          acc        <= beat;
          lane       <= lane + LW'(1);
          first_beat <= sob_n;
          state      <= IN_PKT;
        end
      end
    end
  end

  // A completion can only occur when the output slot is free or draining.
  always_ff @(posedge clk_in_clk) begin
    if (reset_in_rst) begin
      valid_tx          <= 1'b0;
      data_tx           <= '0;
      start_of_burst_tx <= 1'b0;
      end_of_burst_tx   <= 1'b0;
    end else if (done) begin
      valid_tx          <= 1'b1;
      data_tx           <= beat;
      start_of_burst_tx <= sob_n;
      end_of_burst_tx   <= avalonst_sink_endofpacket;
    end else if (valid_tx && ready_tx) begin
      valid_tx          <= 1'b0;
      data_tx           <= '0;
      start_of_burst_tx <= 1'b0;
      end_of_burst_tx   <= 1'b0;
    end
  end

`ifdef SWM_TX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_in_clk) begin
    if (reset_in_rst) begin
      err_cnt_q <= '0;
    end else if (error_tx != 4'b0 && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err;

  assign unused_err = ^error_tx;
  assign err_count  = '0;
`endif

endmodule
